// File: rtl/r5fp_postproc_round_if.sv
// Bus between an FP arithmetic datapath and its post-processing/rounding stage.
// The master drives the unrounded intermediate result; the slave returns the packed result.
interface r5fp_postproc_round_if #(
    parameter int SIG_W   = 23,
    parameter int EXP_W   = 8,
    parameter int I_SIG_W = 28
);
    logic                     in_valid;
    logic [6:0]               aStatus;
    logic                     aSign;
    logic [EXP_W+1:0]         aExp;
    logic [I_SIG_W-1:0]       aSig;
    logic [EXP_W-1:0]         tailZeroCnt;
    logic [2:0]               rnd;
    logic [SIG_W+EXP_W:0]     z;
    logic [7:0]               status;
    logic                     out_valid;

    modport master (
        output in_valid, aStatus, aSign, aExp, aSig, tailZeroCnt, rnd,
        input  z, status, out_valid
    );

    modport slave (
        input  in_valid, aStatus, aSign, aExp, aSig, tailZeroCnt, rnd,
        output z, status, out_valid
    );
endinterface

// File: rtl/r5fp_postproc_round.sv
// Normalise, denormalise, round and pack a wide intermediate FP result into
// IEEE-754 format with exception flags; one registered stage.
module r5fp_postproc_round #(
    parameter int SIG_W   = 23,
    parameter int EXP_W   = 8,
    parameter int I_SIG_W = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    r5fp_postproc_round_if.slave bus
);
    localparam int OUT_W = SIG_W + EXP_W + 1;
    localparam int EW    = EXP_W + 4;
    localparam int SAT   = SIG_W + 2;
    localparam int G_BIT = I_SIG_W - 3 - SIG_W;

    localparam logic signed [EW-1:0] E_ZERO   = '0;
    localparam logic signed [EW-1:0] E_ONE    = EW'(1);
    localparam logic signed [EW-1:0] E_SATLIM = EW'(1 - SAT);
    localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     TZ_LIM   = EXP_W'(I_SIG_W);
    localparam logic [I_SIG_W-1:0]   LOW_MASK = (I_SIG_W'(1) << G_BIT) - I_SIG_W'(1);

    logic [I_SIG_W-1:0]     sig_sh, sig_n, sig_d;
    logic signed [EW-1:0]   exp_a, exp_n, exp_r;
    logic [EW-1:0]          shamt;
    logic [SIG_W:0]         mant;
    logic [SIG_W+1:0]       mant_r;
    logic [SIG_W-1:0]       frac;
    logic [2:0]             mode;
    logic                   stk_n, lost, tiny_range, nonzero;
    logic                   guard, sticky, inc, inexact, huge, ovf_inf;
    logic [OUT_W-1:0]       z_next, z_reg;
    logic [7:0]             status_next, status_reg;
    logic                   out_valid_reg;
    logic                   unused_status;

    assign unused_status = ^{bus.aStatus[6], bus.aStatus[4:3]};

    always_comb begin
        z_next      = '0;
        status_next = '0;

        sig_sh = (bus.tailZeroCnt >= TZ_LIM) ? '0 : (bus.aSig << bus.tailZeroCnt);
        exp_a  = EW'($signed(bus.aExp)) - $signed({{(EW-EXP_W){1'b0}}, bus.tailZeroCnt});

        // Integer-overflow bit set: renormalise right by one.
        stk_n = bus.aStatus[5];
        sig_n = sig_sh;
        exp_n = exp_a;
        if (sig_sh[I_SIG_W-1]) begin
            sig_n = sig_sh >> 1;
            stk_n = bus.aStatus[5] | sig_sh[0];
            exp_n = exp_a + E_ONE;
        end

        tiny_range = (exp_n <= E_ZERO);
        shamt      = '0;
        if (tiny_range)
            shamt = (exp_n <= E_SATLIM) ? EW'(SAT) : (E_ONE - exp_n);
        sig_d = sig_n >> shamt;
        lost  = tiny_range && ((sig_d << shamt) != sig_n);

        mant   = sig_d[I_SIG_W-2 -: SIG_W+1];
        guard  = sig_d[G_BIT];
        sticky = stk_n | lost | ((sig_d & LOW_MASK) != '0);

        mode = (bus.rnd > 3'd5) ? 3'd0 : bus.rnd;
        case (mode)
            3'd1:    inc = 1'b0;
            3'd2:    inc = !bus.aSign & (guard | sticky);
            3'd3:    inc = bus.aSign & (guard | sticky);
            3'd4:    inc = guard;
            3'd5:    inc = guard | sticky;
            default: inc = guard & (sticky | mant[0]);
        endcase
        case (mode)
            3'd1:    ovf_inf = 1'b0;
            3'd2:    ovf_inf = !bus.aSign;
            3'd3:    ovf_inf = bus.aSign;
            default: ovf_inf = 1'b1;
        endcase

        mant_r = {1'b0, mant} + {{(SIG_W+1){1'b0}}, inc};
        // A subnormal that rounds into the hidden bit becomes the smallest normal.
        if (tiny_range)
            exp_r = mant_r[SIG_W] ? E_ONE : E_ZERO;
        else
            exp_r = exp_n + (mant_r[SIG_W+1] ? E_ONE : E_ZERO);
        frac    = mant_r[SIG_W+1] ? mant_r[SIG_W:1] : mant_r[SIG_W-1:0];
        inexact = guard | sticky;
        nonzero = (sig_n != '0) | bus.aStatus[5];
        huge    = (exp_r >= E_MAX);

        if (bus.aStatus[2]) begin
            z_next      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(SIG_W-1){1'b0}}};
            status_next = 8'h04;
        end else if (bus.aStatus[1]) begin
            z_next      = {bus.aSign, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
            status_next = 8'h02;
        end else if (bus.aStatus[0] || (bus.aSig == '0 && !bus.aStatus[5])) begin
            z_next      = {bus.aSign, {(OUT_W-1){1'b0}}};
            status_next = 8'h01;
        end else begin
            status_next[3] = tiny_range & nonzero;
            status_next[5] = inexact;
            if (huge) begin
                status_next[4] = 1'b1;
                status_next[5] = 1'b1;
                z_next = ovf_inf ? {bus.aSign, {EXP_W{1'b1}}, {SIG_W{1'b0}}}
                                 : {bus.aSign, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}};
            end else if (mant_r == '0) begin
                status_next[0] = 1'b1;
                z_next         = {bus.aSign, {(OUT_W-1){1'b0}}};
            end else begin
                z_next = {bus.aSign, exp_r[EXP_W-1:0], frac};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_reg         <= '0;
            status_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                z_reg      <= z_next;
                status_reg <= status_next;
            end
        end
    end

    assign bus.z         = z_reg;
    assign bus.status    = status_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_r5fp_postproc_round.sv
// Scoreboard bench for r5fp_postproc_round: directed vectors with literal results,
// then random traffic checked against an arithmetic reference model.
module tb_r5fp_postproc_round;
    localparam int SIG_W   = 23;
    localparam int EXP_W   = 8;
    localparam int I_SIG_W = 28;

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  st;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    r5fp_postproc_round_if #(.SIG_W(SIG_W), .EXP_W(EXP_W), .I_SIG_W(I_SIG_W)) bus ();

    r5fp_postproc_round #(.SIG_W(SIG_W), .EXP_W(EXP_W), .I_SIG_W(I_SIG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;
    logic        rst_q;
    logic [31:0] last_z  = '0;
    logic [7:0]  last_st = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: value = sig * 2^(e - 26 - 127); rounding by integer quotient/remainder.
    function automatic void ref_model(input logic [6:0] st, input logic sg, input int e_in,
                                      input longint sig_in, input int tzc, input int rm,
                                      output logic [31:0] zo, output logic [7:0] so);
        longint s, q, r, sh;
        int     e, ef, mode;
        bit     stk, tiny, subn, g, inc, inexact, to_inf;
        if (st[2]) begin zo = 32'h7FC00000; so = 8'h04; return; end
        if (st[1]) begin zo = {sg, 8'hFF, 23'h0}; so = 8'h02; return; end
        if (st[0] || (sig_in == 0 && !st[5])) begin zo = {sg, 31'h0}; so = 8'h01; return; end
        mode = (rm > 5) ? 0 : rm;
        stk  = st[5];
        tiny = 0;
        subn = 0;
        s = (tzc >= 28) ? 0 : ((sig_in << tzc) % (64'd1 << 28));
        e = e_in - tzc;
        if (s >= (64'd1 << 27)) begin
            if (s % 2 != 0) stk = 1;
            s = s / 2;
            e = e + 1;
        end
        if (e <= 0) begin
            subn = 1;
            tiny = (s != 0) || st[5];
            sh   = (1 - e > 25) ? 25 : 1 - e;
            if (s % (64'd1 << sh) != 0) stk = 1;
            s = s / (64'd1 << sh);
        end
        q = s / 8;
        r = s % 8;
        g = (r >= 4);
        if (r % 4 != 0) stk = 1;
        case (mode)
            1:       inc = 0;
            2:       inc = !sg && (g || stk);
            3:       inc = sg && (g || stk);
            4:       inc = g;
            5:       inc = g || stk;
            default: inc = g && (stk || (q % 2 == 1));
        endcase
        inexact = g || stk;
        q = q + (inc ? 1 : 0);
        if (subn) begin
            ef = (q >= (64'd1 << 23)) ? 1 : 0;
        end else begin
            ef = e;
            if (q >= (64'd1 << 24)) begin q = q / 2; ef = ef + 1; end
        end
        to_inf = (mode == 0) || (mode == 4) || (mode == 5) || (mode == 2 && !sg) || (mode == 3 && sg);
        if (ef >= 255) begin
            so = 8'h30 | (tiny ? 8'h08 : 8'h00);
            zo = to_inf ? {sg, 8'hFF, 23'h0} : {sg, 8'hFE, 23'h7FFFFF};
        end else if (q == 0) begin
            so = 8'h01 | (tiny ? 8'h08 : 8'h00) | (inexact ? 8'h20 : 8'h00);
            zo = {sg, 31'h0};
        end else begin
            so = (tiny ? 8'h08 : 8'h00) | (inexact ? 8'h20 : 8'h00);
            zo = {sg, 8'(ef), 23'(q % (64'd1 << 23))};
        end
    endfunction

    task automatic apply(input bit v, input bit rst, input logic [6:0] st, input logic sg,
                         input logic [9:0] e, input logic [27:0] sig, input logic [7:0] tzc,
                         input logic [2:0] rm);
        @(posedge clk);
        #1;
        reset           = rst;
        bus.in_valid    = v;
        bus.aStatus     = st;
        bus.aSign       = sg;
        bus.aExp        = e;
        bus.aSig        = sig;
        bus.tailZeroCnt = tzc;
        bus.rnd         = rm;
    endtask

    task automatic directed(input logic [6:0] st, input logic sg, input logic [9:0] e,
                            input logic [27:0] sig, input logic [7:0] tzc, input logic [2:0] rm,
                            input logic [31:0] ez, input logic [7:0] es);
        apply(1'b1, 1'b0, st, sg, e, sig, tzc, rm);
        sb_q.push_back({ez, es});
    endtask

    always @(posedge clk) rst_q <= reset;

    // Monitor: reset clears, valid pops the scoreboard, idle must hold.
    always @(negedge clk) begin
        exp_t ex;
        if (rst_q === 1'b1) begin
            chk("reset_z", bus.z, 32'h0);
            chk("reset_status", {24'h0, bus.status}, 32'h0);
            chk("reset_out_valid", {31'h0, bus.out_valid}, 32'h0);
            last_z  = '0;
            last_st = '0;
        end else if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1 required 0 at %0t", $time);
            end else begin
                ex = sb_q.pop_front();
                n_txn++;
                chk("z", bus.z, ex.z);
                chk("status", {24'h0, bus.status}, {24'h0, ex.st});
                $display("txn %0d z=%h status=%h expect z=%h status=%h", n_txn, bus.z, bus.status, ex.z, ex.st);
                last_z  = ex.z;
                last_st = ex.st;
            end
        end else begin
            chk("hold_z", bus.z, last_z);
            chk("hold_status", {24'h0, bus.status}, {24'h0, last_st});
        end
    end

    initial begin
        logic [27:0] sig;
        logic [9:0]  e;
        logic [7:0]  tzc;
        logic [6:0]  st;
        logic [2:0]  rm;
        logic        sg, v;
        logic [31:0] zo;
        logic [7:0]  so;
        int          lz;

        bus.in_valid = 1'b0; bus.aStatus = '0; bus.aSign = 1'b0; bus.aExp = '0;
        bus.aSig = '0; bus.tailZeroCnt = '0; bus.rnd = '0;
        repeat (3) apply(1'b0, 1'b1, 7'h0, 1'b0, 10'd0, 28'h0, 8'd0, 3'd0);
        apply(1'b0, 1'b0, 7'h0, 1'b0, 10'd0, 28'h0, 8'd0, 3'd0);

        directed(7'h00, 1'b0, 10'd127, 28'h4000000, 8'd0, 3'd0, 32'h3F800000, 8'h00);
        directed(7'h00, 1'b0, 10'd127, 28'h4000004, 8'd0, 3'd0, 32'h3F800000, 8'h20);
        directed(7'h00, 1'b0, 10'd127, 28'h400000C, 8'd0, 3'd0, 32'h3F800002, 8'h20);
        directed(7'h00, 1'b0, 10'd127, 28'h400000C, 8'd0, 3'd7, 32'h3F800002, 8'h20);
        directed(7'h00, 1'b0, 10'd127, 28'h7FFFFFC, 8'd0, 3'd0, 32'h40000000, 8'h20);
        directed(7'h00, 1'b0, 10'd127, 28'h7FFFFFC, 8'd0, 3'd1, 32'h3FFFFFFF, 8'h20);
        directed(7'h00, 1'b0, 10'd254, 28'h8000000, 8'd0, 3'd0, 32'h7F800000, 8'h30);
        directed(7'h00, 1'b0, 10'd254, 28'h8000000, 8'd0, 3'd1, 32'h7F7FFFFF, 8'h30);
        directed(7'h00, 1'b0, 10'd254, 28'h8000000, 8'd0, 3'd3, 32'h7F7FFFFF, 8'h30);
        directed(7'h00, 1'b1, 10'd254, 28'h8000000, 8'd0, 3'd3, 32'hFF800000, 8'h30);
        directed(7'h00, 1'b0, 10'd0,   28'h4000000, 8'd0, 3'd0, 32'h00400000, 8'h08);
        directed(7'h04, 1'b1, 10'd0,   28'h4000000, 8'd0, 3'd0, 32'h7FC00000, 8'h04);
        directed(7'h02, 1'b1, 10'd5,   28'h4000000, 8'd0, 3'd0, 32'hFF800000, 8'h02);
        directed(7'h01, 1'b1, 10'd127, 28'h4000000, 8'd0, 3'd0, 32'h80000000, 8'h01);
        directed(7'h00, 1'b0, 10'd131, 28'h0400000, 8'd4, 3'd0, 32'h3F800000, 8'h00);
        directed(7'h00, 1'b0, 10'd0,   28'h7FFFFFC, 8'd0, 3'd0, 32'h00800000, 8'h28);
        directed(7'h00, 1'b0, 10'h39C, 28'h4000000, 8'd0, 3'd1, 32'h00000000, 8'h29);
        directed(7'h00, 1'b1, 10'h39C, 28'h4000000, 8'd0, 3'd5, 32'h80000001, 8'h28);

        // Reset together with a valid input: nothing may emerge.
        apply(1'b1, 1'b1, 7'h00, 1'b0, 10'd127, 28'h4000000, 8'd0, 3'd0);
        apply(1'b0, 1'b0, 7'h00, 1'b0, 10'd0, 28'h0, 8'd0, 3'd0);
        apply(1'b0, 1'b0, 7'h00, 1'b0, 10'd0, 28'h0, 8'd0, 3'd0);

        for (int i = 0; i < 400; i++) begin
            sig = 28'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: begin sig[27] = 1'b0; sig[26] = 1'b1; end
                2: sig = sig >> $urandom_range(1, 27);
                default: sig[27] = 1'b1;
            endcase
            lz = 28;
            for (int b = 27; b >= 0; b--) if (sig[b] && lz == 28) lz = 27 - b;
            if ($urandom_range(0, 9) == 0)      tzc = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) tzc = 8'((lz >= 1 && lz < 28) ? lz - 1 : 0);
            else                                tzc = 8'($urandom_range(0, (lz < 28) ? lz : 0));
            case ($urandom_range(0, 3))
                0: e = 10'($urandom_range(0, 1023));
                1: e = 10'(int'($urandom_range(0, 60)) - 30);
                2: e = 10'($urandom_range(230, 260));
                default: e = 10'($urandom_range(100, 150));
            endcase
            st = '0;
            if ($urandom_range(0, 15) == 0) st[2] = 1'b1;
            if ($urandom_range(0, 15) == 0) st[1] = 1'b1;
            if ($urandom_range(0, 15) == 0) st[0] = 1'b1;
            st[5] = 1'($urandom_range(0, 1));
            st[6] = 1'($urandom_range(0, 1));
            st[3] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) sig = '0;
            sg = 1'($urandom_range(0, 1));
            rm = 3'($urandom_range(0, 7));
            v  = ($urandom_range(0, 3) != 0);
            apply(v, 1'b0, st, sg, e, sig, tzc, rm);
            if (v) begin
                ref_model(st, sg, int'($signed(e)), longint'(sig), int'(tzc), int'(rm), zo, so);
                sb_q.push_back({zo, so});
            end
        end

        repeat (4) apply(1'b0, 1'b0, 7'h0, 1'b0, 10'd0, 28'h0, 8'd0, 3'd0);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/r5fp_postproc_round.md
# r5fp_postproc_round

Registered floating-point post-processing stage: takes an unrounded, wide-significand intermediate result (sign, biased exponent, significand, sticky/special flags) from an arithmetic datapath (add, mul, div, sqrt) and produces a packed IEEE-754-style result plus an 8-bit exception status. It performs normalisation, denormalisation into subnormal range, rounding in six modes, overflow/underflow handling and special-value encoding. One-cycle latency.

## Interface
- SIG_W, 23, stored fraction width of the result.
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- I_SIG_W, 28, input significand width; must be >= SIG_W+3.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  inputs valid this cycle.
- aStatus  in  7  [0] zero, [1] infinity, [2] invalid/NaN, [5] sticky (nonzero bits discarded below aSig LSB); others ignored.
- aSign  in  1  result sign.
- aExp  in  EXP_W+2  signed two's-complement biased exponent.
- aSig  in  I_SIG_W  significand; binary point between bits I_SIG_W-2 and I_SIG_W-3; bit I_SIG_W-1 is an overflow integer bit.
- tailZeroCnt  in  EXP_W  pre-normalisation left-shift amount (upstream leading-zero count).
- rnd  in  3  0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf, 4 nearest ties-away, 5 away from zero; 6/7 treated as 0.
- z  out  SIG_W+EXP_W+1  {sign, exponent field, fraction}.
- status  out  8  [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge (overflow), [5] inexact, [6],[7] always 0.
- out_valid  out  1  z/status valid.

## Operation
- Priority: invalid > infinity > zero > numeric.
- Invalid: z = {0, all-ones exponent, 1, zeros} (quiet NaN); status = 0x04.
- Infinity: z = {aSign, all-ones, zeros}; status = 0x02.
- Zero flag, or aSig==0 with sticky 0: z = {aSign, zeros}; status = 0x01.
- Numeric path, in order:
  - Left-shift aSig by tailZeroCnt, decrement exponent by same; shifts >= I_SIG_W give zero significand.
  - If bit I_SIG_W-1 set: shift right 1, OR lost bit into sticky, exponent+1.
  - If exponent <= 0: tiny; shift right by 1-exponent (saturate at SIG_W+2), OR lost bits into sticky; exponent field = 0.
  - Keep SIG_W+1 bits from bit I_SIG_W-2 down; guard = next bit; sticky = OR of all lower bits | aStatus[5].
  - Increment when: mode 0: guard & (sticky | lsb); 4: guard; 2: !sign & (guard|sticky); 3: sign & (guard|sticky); 5: guard|sticky; 1: never.
  - Carry to 2.0: shift right, exponent+1. Subnormal rounding up into hidden bit yields exponent field 1.
  - inexact = guard|sticky.
  - Exponent >= 2^EXP_W-1 after rounding: huge+inexact; result infinity for modes 0, 4, 5, mode 2 with positive, mode 3 with negative; otherwise max finite {sign, all-ones minus 1, all-ones fraction}.
  - Rounded result zero: status[0] also set, z = signed zero.
- tiny = pre-rounding exponent <= 0 with nonzero value, regardless of exactness.

## Timing
- Single pipeline stage; datapath combinational, z/status/out_valid registered on rising clk.
- out_valid = in_valid delayed one cycle; z/status capture only when in_valid=1, else hold.
- Back-to-back inputs every cycle; no backpressure.
- Reset: z=0, status=0, out_valid=0; reset dominates in_valid in the same cycle; mid-operation reset discards in-flight result.

## Test plan
- Defaults, rnd=0, aExp=127, aSig=0x4000000 -> next cycle z=0x3F800000, status=0x00, out_valid=1.
- aSig=0x4000004 (tie, lsb 0) -> z=0x3F800000, status=0x20; aSig=0x400000C -> z=0x3F800002, status=0x20.
- aSig=0x7FFFFFC, aExp=127, rnd=0 -> carry, z=0x40000000, status=0x20; rnd=1 -> z=0x3FFFFFFF.
- aExp=254, aSig=0x8000000: rnd=0 -> z=0x7F800000, status=0x30; rnd=1 -> z=0x7F7FFFFF, status=0x30.
- aExp=0, aSig=0x4000000 -> z=0x00400000, status=0x08; aStatus=0x04 -> z=0x7FC00000, status=0x04.
- Assert reset with in_valid=1 -> next cycle z=0, status=0, out_valid=0.
